gfx128_wbm_read_arbiter: RTL

GFX128_WBM_READ_ARBITER -- requirements
Module: gfx128_wbm_read_arbiter

---
 rtl/gfx128_wbm_read_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gfx128_wbm_read_arbiter.sv
// Three-requester round-robin Wishbone read master for the 128-bit graphics bus.
// One read is in flight at a time; completion, error and timeout end in a DONE cycle.
module gfx128_wbm_read_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_i,
    input  logic         req1_i,
    input  logic         req2_i,
    input  logic [27:0]  adr0_i,
    input  logic [27:0]  adr1_i,
    input  logic [27:0]  adr2_i,
    input  logic [15:0]  sel0_i,
    input  logic [15:0]  sel1_i,
    input  logic [15:0]  sel2_i,
    output logic         ack0_o,
    output logic         ack1_o,
    output logic         ack2_o,
    output logic [127:0] dat_o,
    output logic         err_o,
    output logic         busy_o,
    output logic         wb_cyc_o,
    output logic         wb_stb_o,
    output logic         wb_we_o,
    output logic [27:0]  wb_adr_o,
    output logic [15:0]  wb_sel_o,
    input  logic         wb_ack_i,
    input  logic         wb_err_i,
    input  logic [127:0] wb_dat_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [1:0]     r_last;
    logic [1:0]     r_gnt;
    logic [7:0]     r_tmo;
    logic           r_cyc;
    logic [27:0]    r_adr;
    logic [15:0]    r_sel;
    logic [2:0]     r_ack;
    logic           r_err;
    logic           r_busy;
    logic [127:0]   r_dat;

    logic [3:0]     w_req;
    logic           w_gnt_valid;
    logic [1:0]     w_gnt_idx;
    logic [27:0]    w_adr_mux;
    logic [15:0]    w_sel_mux;
    logic           w_timeout;
    logic           w_finish;

    // (base + off) mod 3 for base in 0..2 and off in 1..3.
    function automatic logic [1:0] f_wrap(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3)
            s = s - 3'd3;
        return s[1:0];
    endfunction

    assign w_req       = {1'b0, req2_i, req1_i, req0_i};
    assign w_gnt_valid = |w_req;
    assign w_timeout   = (r_tmo == TMO_LAST);
    assign w_finish    = wb_ack_i | wb_err_i | w_timeout;

    // Scan from the farthest candidate down so the one right after last_grant wins.
    always_comb begin
        w_gnt_idx = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            if (w_req[f_wrap(r_last, 2'(k))])
                w_gnt_idx = f_wrap(r_last, 2'(k));
        end
    end

    always_comb begin
        case (w_gnt_idx)
            2'd1:    begin w_adr_mux = adr1_i; w_sel_mux = sel1_i; end
            2'd2:    begin w_adr_mux = adr2_i; w_sel_mux = sel2_i; end
            default: begin w_adr_mux = adr0_i; w_sel_mux = sel0_i; end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_valid) w_state_next = S_BUS;
            S_BUS:   if (w_finish)    w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last <= 2'd2;
            r_gnt  <= 2'd0;
            r_tmo  <= 8'd0;
            r_cyc  <= 1'b0;
            r_adr  <= 28'd0;
            r_sel  <= 16'd0;
            r_ack  <= 3'd0;
            r_err  <= 1'b0;
            r_busy <= 1'b0;
            r_dat  <= 128'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        r_adr  <= w_adr_mux;
                        r_sel  <= w_sel_mux;
                        r_cyc  <= 1'b1;
                        r_busy <= 1'b1;
                        r_gnt  <= w_gnt_idx;
                        r_last <= w_gnt_idx;
                        r_tmo  <= 8'd0;
                    end
                end
                S_BUS: begin
                    if (w_finish) begin
                        r_cyc <= 1'b0;
                        r_ack <= 3'b001 << r_gnt;
                        // Error and timeout both report err; only a clean ack returns data.
                        r_err <= wb_err_i | ~wb_ack_i;
                        r_dat <= (wb_ack_i & ~wb_err_i) ? wb_dat_i : 128'd0;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_DONE: begin
                    r_ack  <= 3'd0;
                    r_err  <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_cyc  <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign ack0_o   = r_ack[0];
    assign ack1_o   = r_ack[1];
    assign ack2_o   = r_ack[2];
    assign dat_o    = r_dat;
    assign err_o    = r_err;
    assign busy_o   = r_busy;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = 1'b0;
    assign wb_adr_o = r_adr;
    assign wb_sel_o = r_sel;

endmodule
